// File: rtl/titan_comms_pkg.sv
// TitanComms shared definitions: host opcodes and the scheduler FSM state type.
package TitanComms;

   localparam logic [7:0] WRITE          = 8'h01;
   localparam logic [7:0] READ           = 8'h02;
   localparam logic [7:0] TRANSFER       = 8'h03;
   localparam logic [7:0] REPEAT         = 8'h04;
   localparam logic [7:0] BIND_INTERRUPT = 8'h05;
   localparam logic [7:0] BIND_ADDRESS   = 8'h06;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      DONE
   } sched_state_t;

endpackage

// File: rtl/command_scheduler_fifo.sv
// Synchronous command FIFO with registered occupancy count; full/empty decode from the count.
module cmd_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // Power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         if (do_wr && !do_rd)      count <= count + (AW+1)'(1);
         else if (do_rd && !do_wr) count <= count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/command_scheduler.sv
// Drains queued host commands onto the core register bus, one req/ack transaction at a time.
module command_scheduler
   import TitanComms::*;
#(
   parameter int INSTRUCTION_WIDTH = 8,
   parameter int ADDRESS_WIDTH     = 24,
   parameter int VALUE_WIDTH       = 32,
   parameter int FIFO_DEPTH        = 4,
   parameter int TIMEOUT_CYCLES    = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [INSTRUCTION_WIDTH-1:0] cmd_instruction,
   input  logic [ADDRESS_WIDTH-1:0]     cmd_address,
   input  logic [VALUE_WIDTH-1:0]       cmd_value,
   output logic                         core_req,
   output logic                         core_we,
   output logic [ADDRESS_WIDTH-1:0]     core_address,
   output logic [VALUE_WIDTH-1:0]       core_wdata,
   input  logic                         core_ack,
   input  logic [VALUE_WIDTH-1:0]       core_rdata,
   output logic [VALUE_WIDTH-1:0]       read_value,
   output logic                         read_value_valid,
   output logic [ADDRESS_WIDTH-1:0]     interrupt_address,
   output logic [ADDRESS_WIDTH-1:0]     stream_address,
   output logic                         busy,
   input  logic                         clear_errors,
   output logic                         error_timeout,
   output logic                         error_opcode
);

   localparam int CMD_W = INSTRUCTION_WIDTH + ADDRESS_WIDTH + VALUE_WIDTH;
   localparam logic [INSTRUCTION_WIDTH-1:0] OP_WRITE = INSTRUCTION_WIDTH'(WRITE);
   localparam logic [INSTRUCTION_WIDTH-1:0] OP_READ  = INSTRUCTION_WIDTH'(READ);
   localparam logic [INSTRUCTION_WIDTH-1:0] OP_BIRQ  = INSTRUCTION_WIDTH'(BIND_INTERRUPT);
   localparam logic [INSTRUCTION_WIDTH-1:0] OP_BSTR  = INSTRUCTION_WIDTH'(BIND_ADDRESS);
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   logic [CMD_W-1:0]             head;
   logic [INSTRUCTION_WIDTH-1:0] head_op;
   logic [ADDRESS_WIDTH-1:0]     head_addr;
   logic [VALUE_WIDTH-1:0]       head_val;
   logic                         fifo_full;
   logic                         fifo_empty;
   logic [$clog2(FIFO_DEPTH):0]  fifo_count;

   sched_state_t state, state_next;
   logic         pop, load_xact, set_irq, set_stream, bad_op, ack_hit, timed_out;
   logic         done_hold;
   logic [7:0]   timer;
   logic [7:0]   timer_inc;

   assign {head_op, head_addr, head_val} = head;
   assign cmd_ready = !fifo_full;
   assign busy      = (state != IDLE) || (fifo_count != '0);
   assign timer_inc = timer + 8'd1;

   cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (cmd_valid && cmd_ready),
      .wr_data ({cmd_instruction, cmd_address, cmd_value}),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      load_xact  = 1'b0;
      set_irq    = 1'b0;
      set_stream = 1'b0;
      bad_op     = 1'b0;
      ack_hit    = 1'b0;
      timed_out  = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (head_op == OP_WRITE || head_op == OP_READ) begin
                  load_xact  = 1'b1;
                  state_next = ISSUE;
               end else if (head_op == OP_BIRQ) begin
                  set_irq = 1'b1;
               end else if (head_op == OP_BSTR) begin
                  set_stream = 1'b1;
               end else begin
                  bad_op = 1'b1;
               end
            end
         end
         ISSUE: state_next = WAIT_ACK;
         WAIT_ACK: begin
            if (core_req && core_ack) begin
               ack_hit    = 1'b1;
               state_next = DONE;
            end else if (timer_inc == TIMEOUT_LIMIT) begin
               timed_out  = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            // DONE spans two cycles so the valid pulse lands before IDLE resumes popping.
            if (done_hold) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_req          <= 1'b0;
         core_we           <= 1'b0;
         core_address      <= '0;
         core_wdata        <= '0;
         read_value        <= '0;
         read_value_valid  <= 1'b0;
         interrupt_address <= '0;
         stream_address    <= '0;
         error_timeout     <= 1'b0;
         error_opcode      <= 1'b0;
         timer             <= '0;
         done_hold         <= 1'b0;
      end else begin
         if (load_xact) begin
            core_we      <= (head_op == OP_WRITE);
            core_address <= head_addr;
            core_wdata   <= head_val;
         end
         if (state == ISSUE)             core_req <= 1'b1;
         else if (ack_hit || timed_out)  core_req <= 1'b0;
         if (state == ISSUE)                      timer <= '0;
         else if (state == WAIT_ACK && !ack_hit)  timer <= timer_inc;
         if (ack_hit && !core_we)         read_value <= core_rdata;
         else if (timed_out && !core_we)  read_value <= '1;
         done_hold        <= (state == DONE) && !done_hold;
         read_value_valid <= (state == DONE) && !done_hold && !core_we;
         if (set_irq)    interrupt_address <= head_addr;
         if (set_stream) stream_address    <= head_addr;
         // A new error in the clearing cycle wins.
         error_timeout <= (error_timeout && !clear_errors) || timed_out;
         error_opcode  <= (error_opcode && !clear_errors) || bad_op;
      end
   end

endmodule
